// File: rtl/stream_sorter_pkg.sv
// Shared types and constants for the streaming odd-even transposition sorter.
package stream_sorter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SORT = 2'd1,
        DONE = 2'd2
    } state_t;

    // Sort direction, sampled with each frame.
    localparam logic ASC  = 1'b0;
    localparam logic DESC = 1'b1;

endpackage

// File: rtl/sort_cmp_swap.sv
// Compare-exchange cell: lo goes to the lower index, hi to the higher one.
// Equal operands never swap, so the sort is stable within a pair.
module sort_cmp_swap
    import stream_sorter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             desc,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi,
    output logic             swapped
);

    assign swapped = (desc == ASC) ? (a > b) : (a < b);
    assign lo      = swapped ? b : a;
    assign hi      = swapped ? a : b;

endmodule

// File: rtl/stream_sorter.sv
// Sequential sorter: captures one frame, runs one odd-even transposition pass
// per clock and exits after two consecutive swap-free passes or after N passes.
module stream_sorter
    import stream_sorter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N     = 8,
    parameter int PW    = $clog2(N) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic               in_desc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N*WIDTH-1:0] out_data,
    output logic [PW-1:0]      out_passes
);

    localparam int            HALF   = N / 2;
    localparam logic [PW-1:0] LAST_K = PW'(N - 1);

    state_t                    state;
    logic [N-1:0][WIDTH-1:0]   data;
    logic [N-1:0][WIDTH-1:0]   nxt;
    logic                      desc;
    logic                      prev_zero;
    logic                      any_swap;
    logic                      exit_now;
    logic [PW-1:0]             k;

    logic [HALF-1:0][WIDTH-1:0] ca, cb, clo, chi;
    logic [HALF-1:0]            csw;

    // One cell per even pair; odd passes shift the cells by one element.
    // The last cell has no odd-pass pair and its result is ignored then.
    generate
        for (genvar i = 0; i < HALF; i++) begin : g_cell
            if (i < HALF - 1) begin : g_mid
                assign ca[i] = k[0] ? data[2*i+1] : data[2*i];
                assign cb[i] = k[0] ? data[2*i+2] : data[2*i+1];
            end else begin : g_last
                assign ca[i] = data[2*i];
                assign cb[i] = data[2*i+1];
            end
            sort_cmp_swap #(.WIDTH(WIDTH)) u_cs (
                .a       (ca[i]),
                .b       (cb[i]),
                .desc    (desc),
                .lo      (clo[i]),
                .hi      (chi[i]),
                .swapped (csw[i])
            );
        end
    endgenerate

    // Assemble the frame after the current pass and OR the swap flags.
    always_comb begin
        nxt      = data;
        any_swap = 1'b0;
        if (!k[0]) begin
            for (int i = 0; i < HALF; i++) begin
                nxt[2*i]   = clo[i];
                nxt[2*i+1] = chi[i];
                any_swap   = any_swap | csw[i];
            end
        end else begin
            for (int i = 0; i < HALF - 1; i++) begin
                nxt[2*i+1] = clo[i];
                nxt[2*i+2] = chi[i];
                any_swap   = any_swap | csw[i];
            end
        end
    end

    // Two quiet passes in a row (one of each parity) mean the frame is sorted.
    assign exit_now = (k == LAST_K) || ((k != '0) && !any_swap && prev_zero);

    assign out_data = data;

    // Control FSM with registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_passes <= '0;
            data       <= '0;
            desc       <= ASC;
            k          <= '0;
            prev_zero  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        data      <= in_data;
                        desc      <= in_desc;
                        k         <= '0;
                        prev_zero <= 1'b0;
                        in_ready  <= 1'b0;
                        state     <= SORT;
                    end
                end
                SORT: begin
                    data      <= nxt;
                    prev_zero <= !any_swap;
                    if (exit_now) begin
                        out_passes <= k + PW'(1);
                        out_valid  <= 1'b1;
                        state      <= DONE;
                    end else begin
                        k <= k + PW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stream_sorter.sv
// Directed and randomized bench for stream_sorter (WIDTH=8, N=8).
module tb_stream_sorter;

    localparam int W  = 8;
    localparam int N  = 8;
    localparam int PW = $clog2(N) + 1;

    typedef logic [N*W-1:0] frame_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    frame_t        in_data;
    logic          in_desc;
    logic          out_valid;
    logic          out_ready;
    frame_t        out_data;
    logic [PW-1:0] out_passes;

    int checks = 0;
    int errors = 0;

    stream_sorter #(.WIDTH(W), .N(N), .PW(PW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_desc    (in_desc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_passes (out_passes)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic frame_t mk(input int v[N]);
        frame_t f = '0;
        for (int i = 0; i < N; i++) f[i*W +: W] = v[i][W-1:0];
        return f;
    endfunction

    // Expected output: plain library sort of the element values.
    function automatic frame_t ref_sort(input frame_t f, input logic d);
        int q[$];
        frame_t r = '0;
        for (int i = 0; i < N; i++) q.push_back(int'(f[i*W +: W]));
        if (d) q.rsort(); else q.sort();
        for (int i = 0; i < N; i++) r[i*W +: W] = q[i][W-1:0];
        return r;
    endfunction

    // Expected pass count from the transposition rules on an int array.
    function automatic int ref_passes(input frame_t f, input logic d);
        int a[N];
        int tmp;
        bit sw;
        bit prevz = 0;
        for (int i = 0; i < N; i++) a[i] = int'(f[i*W +: W]);
        for (int k = 0; k < N; k++) begin
            sw = 0;
            for (int i = k % 2; i + 1 < N; i += 2) begin
                if (d ? (a[i] < a[i+1]) : (a[i] > a[i+1])) begin
                    tmp = a[i]; a[i] = a[i+1]; a[i+1] = tmp;
                    sw = 1;
                end
            end
            if (k == N - 1 || (k >= 1 && !sw && prevz)) return k + 1;
            prevz = !sw;
        end
        return N;
    endfunction

    task automatic send(input frame_t f, input logic d);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_ready got %b exp 1", in_ready);
        end
        in_valid = 1'b1;
        in_data  = f;
        in_desc  = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = {$urandom, $urandom};
        in_desc  = 1'($urandom_range(0, 1));
    endtask

    // Cycles from the handshake edge until out_valid is seen; -1 on timeout.
    task automatic wait_out(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 100);
        if (!out_valid) lat = -1;
    endtask

    task automatic accept();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0; in_desc = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++;
        if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got %h exp 0", out_data); end
        checks++;
        if (out_passes !== '0) begin errors++; $display("FAIL reset_out_passes got %0d exp 0", out_passes); end
        rst = 1'b0;
    endtask

    task automatic test_known();
        int v[N]; int e[N]; int lat; frame_t f, exp_f;
        v = '{1, 2, 12, 8, 4, 10, 6, 3};
        e = '{1, 2, 3, 4, 6, 8, 10, 12};
        f = mk(v); exp_f = mk(e);
        send(f, 1'b0);
        wait_out(lat);
        checks++;
        if (out_data !== exp_f) begin errors++; $display("FAIL known_data got %h exp %h", out_data, exp_f); end
        checks++;
        if (out_passes < 2 || out_passes > N) begin errors++; $display("FAIL known_range got %0d exp 2..%0d", out_passes, N); end
        checks++;
        if (int'(out_passes) !== ref_passes(f, 1'b0)) begin
            errors++; $display("FAIL known_passes got %0d exp %0d", out_passes, ref_passes(f, 1'b0));
        end
        checks++;
        if (lat !== int'(out_passes) + 1) begin errors++; $display("FAIL known_latency got %0d exp %0d", lat, out_passes + 1); end
        accept();
    endtask

    task automatic test_presorted();
        int v[N]; int lat; frame_t f;
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < N; i++) v[i] = (pass == 0) ? i : N - 1 - i;
            f = mk(v);
            send(f, pass[0]);
            wait_out(lat);
            checks++;
            if (out_data !== f) begin errors++; $display("FAIL presorted_data dir %0d got %h exp %h", pass, out_data, f); end
            checks++;
            if (out_passes !== PW'(2)) begin errors++; $display("FAIL presorted_passes dir %0d got %0d exp 2", pass, out_passes); end
            checks++;
            if (lat !== 3) begin errors++; $display("FAIL presorted_latency dir %0d got %0d exp 3", pass, lat); end
            accept();
        end
    endtask

    task automatic test_reverse();
        int v[N]; int e[N]; int lat; frame_t f, exp_f;
        for (int i = 0; i < N; i++) begin
            v[i] = 200 - 20 * i;
            e[i] = 60 + 20 * i;
        end
        f = mk(v); exp_f = mk(e);
        send(f, 1'b0);
        wait_out(lat);
        checks++;
        if (out_data !== exp_f) begin errors++; $display("FAIL reverse_asc_data got %h exp %h", out_data, exp_f); end
        checks++;
        if (out_passes !== PW'(N)) begin errors++; $display("FAIL reverse_asc_passes got %0d exp %0d", out_passes, N); end
        checks++;
        if (lat !== N + 1) begin errors++; $display("FAIL reverse_asc_latency got %0d exp %0d", lat, N + 1); end
        accept();
        send(f, 1'b1);
        wait_out(lat);
        checks++;
        if (out_data !== f) begin errors++; $display("FAIL reverse_desc_data got %h exp %h", out_data, f); end
        checks++;
        if (out_passes !== PW'(2)) begin errors++; $display("FAIL reverse_desc_passes got %0d exp 2", out_passes); end
        accept();
    endtask

    task automatic test_dups_hold();
        int v[N]; int e[N]; int lat; frame_t f, exp_f;
        bit hold_bad = 0; bit idle_bad = 0;
        v = '{5, 5, 3, 3, 9, 9, 0, 0};
        e = '{0, 0, 3, 3, 5, 5, 9, 9};
        f = mk(v); exp_f = mk(e);
        send(f, 1'b0);
        wait_out(lat);
        checks++;
        if (out_data !== exp_f) begin errors++; $display("FAIL dups_data got %h exp %h", out_data, exp_f); end
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            in_data  = {$urandom, $urandom};
            @(negedge clk);
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== exp_f) hold_bad = 1;
        end
        in_valid = 1'b0;
        checks++;
        if (hold_bad) begin
            errors++;
            $display("FAIL dups_hold got v=%b r=%b d=%h exp v=1 r=0 d=%h", out_valid, in_ready, out_data, exp_f);
        end
        accept();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL dups_release got v=%b r=%b exp v=0 r=1", out_valid, in_ready);
        end
        repeat (4) begin
            @(negedge clk);
            if (out_valid !== 1'b0) idle_bad = 1;
        end
        checks++;
        if (idle_bad) begin errors++; $display("FAIL dups_ignored_input got out_valid=1 exp 0"); end
    endtask

    task automatic test_reset_mid();
        int v[N]; int e[N]; int lat; frame_t f, exp_f;
        for (int i = 0; i < N; i++) v[i] = 200 - 20 * i;
        send(mk(v), 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL midrst_async got v=%b r=%b exp v=0 r=1", out_valid, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL midrst_after got v=%b r=%b exp v=0 r=1", out_valid, in_ready);
        end
        v = '{4, 3, 2, 1, 0, 0, 0, 0};
        e = '{0, 0, 0, 0, 1, 2, 3, 4};
        f = mk(v); exp_f = mk(e);
        send(f, 1'b0);
        wait_out(lat);
        checks++;
        if (out_data !== exp_f) begin errors++; $display("FAIL midrst_data got %h exp %h", out_data, exp_f); end
        checks++;
        if (int'(out_passes) !== ref_passes(f, 1'b0)) begin
            errors++; $display("FAIL midrst_passes got %0d exp %0d", out_passes, ref_passes(f, 1'b0));
        end
        accept();
    endtask

    task automatic test_random();
        frame_t f, exp_f;
        logic d;
        int lat, exp_p, stall;
        bit hold_bad;
        for (int n = 0; n < 1000; n++) begin
            d = 1'($urandom_range(0, 1));
            for (int i = 0; i < N; i++)
                f[i*W +: W] = (n % 3 == 0) ? W'($urandom_range(0, 3)) : W'($urandom_range(0, 255));
            exp_f = ref_sort(f, d);
            exp_p = ref_passes(f, d);
            send(f, d);
            wait_out(lat);
            checks++;
            if (out_data !== exp_f) begin
                errors++; $display("FAIL rand_data #%0d desc=%b in %h got %h exp %h", n, d, f, out_data, exp_f);
            end
            checks++;
            if (int'(out_passes) !== exp_p || out_passes > N) begin
                errors++; $display("FAIL rand_passes #%0d got %0d exp %0d", n, out_passes, exp_p);
            end
            checks++;
            if (lat !== exp_p + 1) begin errors++; $display("FAIL rand_latency #%0d got %0d exp %0d", n, lat, exp_p + 1); end
            stall = $urandom_range(0, 3);
            hold_bad = 0;
            for (int c = 0; c < stall; c++) begin
                @(negedge clk);
                if (out_valid !== 1'b1 || out_data !== exp_f) hold_bad = 1;
            end
            checks++;
            if (hold_bad) begin errors++; $display("FAIL rand_hold #%0d got v=%b d=%h exp v=1 d=%h", n, out_valid, out_data, exp_f); end
            accept();
        end
    endtask

    initial begin
        test_reset();
        test_known();
        test_presorted();
        test_reverse();
        test_dups_hold();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_sorter.md
Name: stream_sorter

Overview:
- Parametrised, sequential successor to the team's fixed 8×8-bit combinational sorter.
- Accepts one frame of N unsigned WIDTH-bit elements over a valid/ready handshake.
- Sorts the frame in place with odd-even transposition, one pass per clock, and exits early once the frame is sorted.
- Returns the frame over a second valid/ready handshake; sort direction is selected per frame.

Parameters:
- WIDTH, 8: element width in bits (unsigned).
- N, 8: elements per frame; must be even and ≥ 2.
- PW, $clog2(N)+1: width of the pass-count output.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  input frame available.
- in_ready  out  1  block accepts a frame.
- in_data  in  N*WIDTH  element i = in_data[i*WIDTH +: WIDTH].
- in_desc  in  1  direction, sampled with the frame: 0 = ascending, 1 = descending.
- out_valid  out  1  sorted frame available.
- out_ready  in  1  consumer accepts the frame.
- out_data  out  N*WIDTH  sorted frame; element 0 is the min (ascending) or the max (descending).
- out_passes  out  PW  number of passes the frame used.

Behaviour:
- Reset (async assert, synchronous release):
  - state = IDLE; in_ready = 1; out_valid = 0; out_data = 0; out_passes = 0.
  - Internal registers and pass counter cleared.
- States:
  - IDLE: in_ready = 1. On in_valid, capture in_data and in_desc, set k = 0, go to SORT.
  - SORT: in_ready = 0, out_valid = 0. Run pass k every cycle.
  - DONE: out_valid = 1. On out_ready, go to IDLE.
- Pass k, compare-exchange pairs:
  - k even: pairs (0,1), (2,3), …, (N-2,N-1).
  - k odd: pairs (1,2), …, (N-3,N-2).
  - Ascending: swap only if lower index > higher index, strictly. Descending: swap only if lower index < higher index, strictly. Equal elements never swap.
- SORT exit, evaluated at the end of pass k:
  - Exit if k == N-1, or if k ≥ 1 and passes k and k-1 both made zero swaps.
  - On exit, out_passes = k+1, then go to DONE. Otherwise k increments.
  - N = 2: odd passes have no pairs and count as zero-swap.
- Latency:
  - Input handshake in cycle t → out_valid first high in cycle t+1+P.
  - P = passes used, 2 ≤ P ≤ N.
- DONE hold: out_data and out_passes stay stable while out_valid=1 and out_ready=0.
- Handshake rules:
  - in_ready=0 in SORT and DONE; no input overlap.
  - Throughput is one frame per P+2 cycles at minimum.
  - In IDLE, in_valid with out_ready is irrelevant.
  - out_valid falls the cycle after the handshake.
- Reset mid-operation: any state returns to IDLE immediately. The in-flight frame is discarded and out_valid drops asynchronously.
- Inputs outside IDLE are ignored; in_desc is used only at capture.

Decomposition:
- Package stream_sorter_pkg:
  - state typedef enum logic [1:0] {IDLE, SORT, DONE}.
  - Direction constants ASC = 0, DESC = 1.
- Sub-module sort_cmp_swap:
  - Combinational compare-exchange cell; params WIDTH.
  - Ports a, b, desc → lo, hi, swapped.
  - N/2 instances are generated and muxed by pass parity.
  - The swapped flags are OR-reduced per pass.

Test Plan:
- Known frame, ascending, N=8: in = {1,2,12,8,4,10,6,3} → out = {1,2,3,4,6,8,10,12}; 2 ≤ out_passes ≤ 8; latency = out_passes+1.
- Already sorted {0,1,…,7}, handshake in cycle t → out_valid at t+3, out_passes=2, data unchanged. Descending on {7,…,0} gives the same.
- Reverse frame {200,180,…,60} ascending → fully sorted, out_passes=8, out_valid at t+9. Same frame with in_desc=1 → out_passes=2.
- Duplicates {5,5,3,3,9,9,0,0} ascending → {0,0,3,3,5,5,9,9}. Then hold out_ready=0 for 5 cycles: out_data stable, in_ready=0, a second in_valid is ignored.
- Reset mid-SORT (rst pulsed during pass 3): out_valid=0 and in_ready=1 in the cycle after release. A fresh frame {4,3,2,1,0,0,0,0} then sorts to {0,0,0,0,1,2,3,4}.
- Randomized $urandom frames, 1000 of them with random in_desc and random out_ready stalls: compare against a scoreboard sort; every frame is ordered per in_desc, is a permutation of the input, and has out_passes ≤ N.
